// File: rtl/quad_word_loader_if.sv
// Stream-in / frame-out bus of the quad word loader.
// The slave modport is the loader's side; the master modport is the producer/consumer side.
interface quad_word_loader_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       fill_cnt;
  logic [15:0]      frame_cnt;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_a, out_b, out_c, out_d, out_valid, fill_cnt, frame_cnt
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_a, out_b, out_c, out_d, out_valid, fill_cnt, frame_cnt
  );
endinterface

// File: rtl/quad_word_loader.sv
// Groups every 4 accepted words into one frame for the 4-input comparator.
// Double-buffered: a fill stage collects words while the output stage holds the previous frame.
module qwl_lane #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] PAD   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic             pad_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] fill_o,
  output logic [WIDTH-1:0] out_o
);
  logic [WIDTH-1:0] fill_q, fill_d, out_q, out_d;

  always_comb begin
    fill_d = fill_q;
    if (wr_i)       fill_d = data_i;
    else if (pad_i) fill_d = PAD;
    out_d = load_i ? fill_q : out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      out_q  <= '0;
    end else begin
      fill_q <= fill_d;
      out_q  <= out_d;
    end
  end

  assign fill_o = fill_q;
  assign out_o  = out_q;
endmodule

module quad_word_loader #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] PAD   = '0
) (
  input  logic clk,
  input  logic rst_n,
  quad_word_loader_if.slave bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic {FILL, FULL} state_e;

  state_e      state_q;
  logic        in_ready_q;
  logic [2:0]  fill_cnt_q;
  logic        out_valid_q;
  logic [15:0] frame_cnt_q;

  logic acc, close, xfer, handoff;
  logic [NUM_LANES-1:0]            lane_wr, lane_pad;
  logic [NUM_LANES-1:0][WIDTH-1:0] fill_w, out_w;

  assign acc     = bus.in_valid && in_ready_q;
  // A frame closes on its 4th word, or on flush once at least one word is (or is being) stored.
  assign close   = (state_q == FILL) &&
                   ((acc && fill_cnt_q == 3'd3) || (bus.flush && (acc || fill_cnt_q != 3'd0)));
  assign xfer    = (state_q == FULL) && (!out_valid_q || bus.out_ready);
  assign handoff = out_valid_q && bus.out_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // The incoming word takes its slot first; padding only fills the slots above it.
    assign lane_wr[i]  = acc && (fill_cnt_q == 3'(i));
    assign lane_pad[i] = close && !lane_wr[i] && (fill_cnt_q <= 3'(i));

    qwl_lane #(.WIDTH(WIDTH), .PAD(PAD)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_i   (lane_wr[i]),
      .pad_i  (lane_pad[i]),
      .load_i (xfer),
      .data_i (bus.in_data),
      .fill_o (fill_w[i]),
      .out_o  (out_w[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      in_ready_q  <= 1'b1;
      fill_cnt_q  <= 3'd0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      if (handoff) frame_cnt_q <= frame_cnt_q + 16'd1;

      case (state_q)
        FILL: begin
          if (close) begin
            state_q    <= FULL;
            in_ready_q <= 1'b0;
            fill_cnt_q <= 3'd4;
          end else if (acc) begin
            fill_cnt_q <= fill_cnt_q + 3'd1;
          end
        end
        FULL: begin
          if (xfer) begin
            state_q    <= FILL;
            in_ready_q <= 1'b1;
            fill_cnt_q <= 3'd0;
          end
        end
        default: begin
          state_q    <= FILL;
          in_ready_q <= 1'b1;
          fill_cnt_q <= 3'd0;
        end
      endcase

      if (xfer)         out_valid_q <= 1'b1;
      else if (handoff) out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fill_cnt  = fill_cnt_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.out_a     = out_w[0];
  assign bus.out_b     = out_w[1];
  assign bus.out_c     = out_w[2];
  assign bus.out_d     = out_w[3];
endmodule

// File: tb/tb_quad_word_loader.sv
// Directed bench for quad_word_loader: framing, backpressure, flush, counter wrap, async reset.
module tb_quad_word_loader;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  quad_word_loader_if #(.WIDTH(WIDTH)) bus ();

  quad_word_loader #(.WIDTH(WIDTH), .PAD('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until the word is taken; a stuck in_ready counts as a failure.
  task automatic send(input logic [WIDTH-1:0] w);
    int waitc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && waitc < 50) begin
      tick();
      waitc++;
    end
    if (!bus.in_ready) begin
      $display("FAIL send_timeout: in_ready=%0b want 1", bus.in_ready);
      bad++;
      total++;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.flush = 0; bus.out_ready = 0;
    rst_n = 0;
    #12;
    rst_n = 1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); bad++; end
    total++; if (bus.fill_cnt !== 3'd0) begin $display("FAIL reset_fill_cnt: got %0d want 0", bus.fill_cnt); bad++; end
    total++; if (bus.frame_cnt !== 16'd0) begin $display("FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt); bad++; end
    total++; if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== 128'd0) begin
      $display("FAIL reset_out_words: got %h want 0", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}); bad++; end
    total++; if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); bad++; end
  endtask

  task automatic test_basic_frame();
    bus.out_ready = 1;
    send(5); send(5); send(0); send(0);
    total++; if (bus.fill_cnt !== 3'd4 || bus.in_ready !== 1'b0) begin
      $display("FAIL basic_full: fill_cnt=%0d in_ready=%0b want 4,0", bus.fill_cnt, bus.in_ready); bad++; end
    total++; if (bus.out_valid !== 1'b0) begin $display("FAIL basic_latency1: out_valid=%0b want 0", bus.out_valid); bad++; end
    tick();
    total++; if (bus.out_valid !== 1'b1) begin $display("FAIL basic_latency2: out_valid=%0b want 1", bus.out_valid); bad++; end
    total++; if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== {32'd5, 32'd5, 32'd0, 32'd0}) begin
      $display("FAIL basic_frame: got %h want 5,5,0,0", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}); bad++; end
    total++; if (bus.fill_cnt !== 3'd0 || bus.in_ready !== 1'b1) begin
      $display("FAIL basic_refill: fill_cnt=%0d in_ready=%0b want 0,1", bus.fill_cnt, bus.in_ready); bad++; end
    tick();
    total++; if (bus.frame_cnt !== 16'd1 || bus.out_valid !== 1'b0) begin
      $display("FAIL basic_handoff: frame_cnt=%0d out_valid=%0b want 1,0", bus.frame_cnt, bus.out_valid); bad++; end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 0;
    for (int i = 1; i <= 8; i++) send(WIDTH'(i));
    tick(); tick();
    total++; if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== {32'd1, 32'd2, 32'd3, 32'd4} || bus.out_valid !== 1'b1) begin
      $display("FAIL bp_hold: got %h v=%0b want 1,2,3,4 v=1", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.out_valid); bad++; end
    total++; if (bus.fill_cnt !== 3'd4 || bus.in_ready !== 1'b0) begin
      $display("FAIL bp_fill: fill_cnt=%0d in_ready=%0b want 4,0", bus.fill_cnt, bus.in_ready); bad++; end
    bus.out_ready = 1;
    tick();
    total++; if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== {32'd5, 32'd6, 32'd7, 32'd8} || bus.out_valid !== 1'b1) begin
      $display("FAIL bp_second: got %h v=%0b want 5,6,7,8 v=1", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.out_valid); bad++; end
    total++; if (bus.frame_cnt !== 16'd2 || bus.in_ready !== 1'b1 || bus.fill_cnt !== 3'd0) begin
      $display("FAIL bp_release: frame_cnt=%0d in_ready=%0b fill_cnt=%0d want 2,1,0", bus.frame_cnt, bus.in_ready, bus.fill_cnt); bad++; end
    tick();
    total++; if (bus.frame_cnt !== 16'd3 || bus.out_valid !== 1'b0) begin
      $display("FAIL bp_drain: frame_cnt=%0d out_valid=%0b want 3,0", bus.frame_cnt, bus.out_valid); bad++; end
  endtask

  task automatic test_flush();
    bus.out_ready = 1;
    send(3); send(10);
    bus.flush = 1; tick(); bus.flush = 0;
    total++; if (bus.fill_cnt !== 3'd4) begin $display("FAIL flush_full: fill_cnt=%0d want 4", bus.fill_cnt); bad++; end
    tick();
    total++; if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== {32'd3, 32'd10, 32'd0, 32'd0} || bus.out_valid !== 1'b1) begin
      $display("FAIL flush_frame: got %h v=%0b want 3,10,0,0 v=1", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.out_valid); bad++; end
    total++; if (bus.fill_cnt !== 3'd0) begin $display("FAIL flush_cnt_clear: fill_cnt=%0d want 0", bus.fill_cnt); bad++; end
    tick();
    bus.flush = 1; tick(); bus.flush = 0;
    total++; if (bus.fill_cnt !== 3'd0 || bus.in_ready !== 1'b1) begin
      $display("FAIL flush_empty: fill_cnt=%0d in_ready=%0b want 0,1", bus.fill_cnt, bus.in_ready); bad++; end
    tick(); tick();
    total++; if (bus.out_valid !== 1'b0 || bus.frame_cnt !== 16'd4) begin
      $display("FAIL flush_empty_noframe: out_valid=%0b frame_cnt=%0d want 0,4", bus.out_valid, bus.frame_cnt); bad++; end
  endtask

  task automatic test_flush_with_word();
    bus.out_ready = 1;
    send(7); send(9);
    bus.flush = 1; send(15); bus.flush = 0;
    total++; if (bus.fill_cnt !== 3'd4) begin $display("FAIL flushw_full: fill_cnt=%0d want 4", bus.fill_cnt); bad++; end
    tick();
    total++; if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== {32'd7, 32'd9, 32'd15, 32'd0}) begin
      $display("FAIL flushw_frame: got %h want 7,9,15,0", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}); bad++; end
    tick();
    send(21); send(22); send(23);
    bus.flush = 1; send(24); bus.flush = 0;
    tick();
    total++; if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== {32'd21, 32'd22, 32'd23, 32'd24}) begin
      $display("FAIL flush4_frame: got %h want 21,22,23,24", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}); bad++; end
    tick();
    total++; if (bus.frame_cnt !== 16'd6 || bus.fill_cnt !== 3'd0 || bus.out_valid !== 1'b0) begin
      $display("FAIL flush4_after: frame_cnt=%0d fill_cnt=%0d v=%0b want 6,0,0", bus.frame_cnt, bus.fill_cnt, bus.out_valid); bad++; end
  endtask

  task automatic test_wrap();
    bus.out_ready = 1;
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    total++; if (bus.frame_cnt !== 16'hFFFF) begin $display("FAIL wrap_preload: got %h want ffff", bus.frame_cnt); bad++; end
    send(1); send(2); send(3); send(4);
    tick(); tick();
    total++; if (bus.frame_cnt !== 16'd0) begin $display("FAIL wrap: frame_cnt=%h want 0", bus.frame_cnt); bad++; end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 0;
    send(11); send(12); send(13); send(14);
    tick();
    send(41); send(42);
    total++; if (bus.out_valid !== 1'b1 || bus.fill_cnt !== 3'd2) begin
      $display("FAIL mid_setup: out_valid=%0b fill_cnt=%0d want 1,2", bus.out_valid, bus.fill_cnt); bad++; end
    #2;
    rst_n = 0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.fill_cnt !== 3'd0 || bus.frame_cnt !== 16'd0) begin
      $display("FAIL mid_async: out_valid=%0b fill_cnt=%0d frame_cnt=%0d want 0,0,0", bus.out_valid, bus.fill_cnt, bus.frame_cnt); bad++; end
    @(negedge clk);
    rst_n = 1;
    bus.out_ready = 1;
    #1;
    send(31); send(32); send(33); send(34);
    tick();
    total++; if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== {32'd31, 32'd32, 32'd33, 32'd34} || bus.out_valid !== 1'b1) begin
      $display("FAIL mid_fresh: got %h v=%0b want 31,32,33,34 v=1", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.out_valid); bad++; end
    tick();
    total++; if (bus.frame_cnt !== 16'd1) begin $display("FAIL mid_count: frame_cnt=%0d want 1", bus.frame_cnt); bad++; end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_flush();
    test_flush_with_word();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
